mbist_march_ctrl: RTL

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_if.sv | 31 +++
 rtl/mbist_march_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mbist_march_if.sv
// Memory-test bus between the March controller and the memory under test,
// together with the controller's status and first-failure report.
interface mbist_march_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [2:0]            fail_elem;
  logic [DATA_WIDTH-1:0] fail_data;
  logic [7:0]            err_cnt;

  modport master (
    input  start, rdata,
    output write_read, address, wdata, busy, done,
    output fail, fail_addr, fail_elem, fail_data, err_cnt
  );

  modport slave (
    output start, rdata,
    input  write_read, address, wdata, busy, done,
    input  fail, fail_addr, fail_elem, fail_data, err_cnt
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: one op per cycle, reads compared two
// cycles after issue, sticky fail flag with first-failure capture.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input logic           clk,
  input logic           rst,
  mbist_march_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY);

  state_t                state, state_nxt;
  logic [2:0]            elem, elem_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [DATA_WIDTH-1:0] bg, bg_nxt;
  logic                  phase, phase_nxt;   // 1 = write slot of the current address
  logic                  drain_cnt, drain_nxt;
  logic                  clear;
  logic                  rd_issue;

  logic                  v1, v2;
  logic [DATA_WIDTH-1:0] exp1, exp2;
  logic [ADDR_WIDTH-1:0] a1, a2;
  logic [2:0]            e1, e2;
  logic                  mismatch;

  logic                  fail_flag;
  logic [ADDR_WIDTH-1:0] bad_addr;
  logic [2:0]            bad_elem;
  logic [DATA_WIDTH-1:0] bad_data;
  logic [7:0]            err_count;

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic has_read(input logic [2:0] e);
    return e != 3'd0;
  endfunction

  function automatic logic has_write(input logic [2:0] e);
    return e != 3'd5;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bg_of(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] exp_of(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
    return is_down(e) ? LAST : '0;
  endfunction

  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    addr_nxt  = addr;
    bg_nxt    = bg;
    phase_nxt = phase;
    drain_nxt = drain_cnt;
    clear     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = SETUP;
          elem_nxt  = 3'd0;
          addr_nxt  = '0;
          bg_nxt    = '0;
          clear     = 1'b1;
        end
      end
      SETUP: begin
        state_nxt = RUN;
        phase_nxt = !has_read(elem);
      end
      RUN: begin
        if (phase || !has_write(elem)) begin
          if (addr == (is_down(elem) ? '0 : LAST)) begin
            if (elem == 3'd5) begin
              state_nxt = DRAIN;
              drain_nxt = 1'b0;
            end else begin
              state_nxt = SETUP;
              elem_nxt  = elem + 3'd1;
              addr_nxt  = first_addr(elem + 3'd1);
              bg_nxt    = bg_of(elem + 3'd1);
            end
          end else begin
            addr_nxt  = is_down(elem) ? addr - 1'b1 : addr + 1'b1;
            phase_nxt = !has_read(elem);
          end
        end else begin
          phase_nxt = 1'b1;
        end
      end
      DRAIN: begin
        drain_nxt = 1'b1;
        if (drain_cnt) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_issue = (state == RUN) && !phase;
  assign mismatch = v2 && (bus.rdata != exp2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= '0;
      addr      <= '0;
      bg        <= '0;
      phase     <= 1'b0;
      drain_cnt <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      exp1      <= '0;
      exp2      <= '0;
      a1        <= '0;
      a2        <= '0;
      e1        <= '0;
      e2        <= '0;
      fail_flag <= 1'b0;
      bad_addr  <= '0;
      bad_elem  <= '0;
      bad_data  <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      elem      <= elem_nxt;
      addr      <= addr_nxt;
      bg        <= bg_nxt;
      phase     <= phase_nxt;
      drain_cnt <= drain_nxt;
      v1        <= rd_issue;
      exp1      <= exp_of(elem);
      a1        <= addr;
      e1        <= elem;
      v2        <= v1;
      exp2      <= exp1;
      a2        <= a1;
      e2        <= e1;
      if (clear) begin
        fail_flag <= 1'b0;
        bad_addr  <= '0;
        bad_elem  <= '0;
        bad_data  <= '0;
        err_count <= '0;
      end else if (mismatch) begin
        fail_flag <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        // Only the first mismatch of a run is reported in detail.
        if (!fail_flag) begin
          bad_addr <= a2;
          bad_elem <= e2;
          bad_data <= bus.rdata;
        end
      end
    end
  end

  assign bus.write_read = (state == RUN) && phase;
  assign bus.address    = addr;
  assign bus.wdata      = bg;
  assign bus.busy       = (state == SETUP) || (state == RUN) || (state == DRAIN);
  assign bus.done       = (state == DONE);
  assign bus.fail       = fail_flag;
  assign bus.fail_addr  = bad_addr;
  assign bus.fail_elem  = bad_elem;
  assign bus.fail_data  = bad_data;
  assign bus.err_cnt    = err_count;
endmodule
